// File: rtl/way_dec_tracker_pkg.sv
// Shared LLC definitions for the way decode/occupancy tracker.
// Holds the default way geometry and the flush FSM state encoding.
package way_dec_tracker_pkg;

    localparam int unsigned LLC_WAYS      = 8;
    localparam int unsigned LLC_WAY_IDX_W = 3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        FLUSH = ST_FLUSH,
        DONE  = ST_DONE
    } state_e;

endpackage

// File: rtl/way_dec_tracker_one_hot_dec.sv
// Binary index to one-hot decoder with enable; out-of-range indices decode to zero.
module one_hot_dec
    import way_dec_tracker_pkg::*;
#(
    parameter int unsigned WIDTH     = LLC_WAYS,
    parameter int unsigned LOG_WIDTH = LLC_WAY_IDX_W
) (
    input  logic [LOG_WIDTH-1:0] i_idx,
    input  logic                 i_en,
    output logic [WIDTH-1:0]     o_oh
);

    always_comb begin
        o_oh = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (i_en && (i_idx == LOG_WIDTH'(i))) begin
                o_oh[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/way_dec_tracker.sv
// LLC way occupancy tracker: one-hot set/clear of a mask, count/full/empty, lowest-first flush drain.
// Optional sticky error output enabled by defining WAY_DEC_TRACKER_ERR_EN.
module way_dec_tracker
    import way_dec_tracker_pkg::*;
#(
    parameter int unsigned WIDTH     = LLC_WAYS,
    parameter int unsigned LOG_WIDTH = LLC_WAY_IDX_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 set_valid,
    input  logic [LOG_WIDTH-1:0] set_idx,
    output logic                 set_ready,
    input  logic                 clr_valid,
    input  logic [LOG_WIDTH-1:0] clr_idx,
    output logic                 clr_ready,
    input  logic                 flush_req,
    output logic                 flush_valid,
    output logic [LOG_WIDTH-1:0] flush_idx,
    input  logic                 flush_ready,
    output logic                 flush_done,
`ifdef WAY_DEC_TRACKER_ERR_EN
    output logic                 err,
`endif
    output logic [WIDTH-1:0]     mask,
    output logic [LOG_WIDTH:0]   count,
    output logic                 full,
    output logic                 empty
);

    localparam int unsigned CNT_W = LOG_WIDTH + 1;

    state_e             r_state;
    state_e             w_state_nxt;
    logic [WIDTH-1:0]   r_mask;
    logic [CNT_W-1:0]   r_count;

    logic               w_set_acc;
    logic               w_clr_acc;
    logic               w_flush_acc;
    logic [WIDTH-1:0]   w_set_oh;
    logic [WIDTH-1:0]   w_clr_oh;
    logic [WIDTH-1:0]   w_flush_oh;
    logic [WIDTH-1:0]   w_mask_nxt;
    logic [CNT_W-1:0]   w_count_nxt;
    logic [LOG_WIDTH-1:0] w_low_idx;

    assign w_set_acc   = set_valid && set_ready;
    assign w_clr_acc   = clr_valid && clr_ready;
    assign w_flush_acc = flush_valid && flush_ready;

    one_hot_dec #(.WIDTH(WIDTH), .LOG_WIDTH(LOG_WIDTH)) u_set_dec (
        .i_idx (set_idx),
        .i_en  (w_set_acc),
        .o_oh  (w_set_oh)
    );

    one_hot_dec #(.WIDTH(WIDTH), .LOG_WIDTH(LOG_WIDTH)) u_clr_dec (
        .i_idx (clr_idx),
        .i_en  (w_clr_acc),
        .o_oh  (w_clr_oh)
    );

    // Lowest occupied way: scan from the top so the last hit wins.
    always_comb begin
        w_low_idx = '0;
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            if (r_mask[i]) begin
                w_low_idx = LOG_WIDTH'(i);
            end
        end
    end

    assign w_flush_oh = w_flush_acc ? (r_mask & (~r_mask + WIDTH'(1))) : '0;
    // Clear before set so a same-index pair leaves the way occupied.
    assign w_mask_nxt = ((r_mask & ~w_clr_oh) | w_set_oh) & ~w_flush_oh;

    always_comb begin
        w_count_nxt = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            w_count_nxt = w_count_nxt + CNT_W'(w_mask_nxt[i]);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (flush_req) begin
                    w_state_nxt = (r_mask == '0) ? DONE : FLUSH;
                end
            end
            FLUSH: begin
                if (r_mask == '0) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_mask  <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_mask  <= w_mask_nxt;
            r_count <= w_count_nxt;
        end
    end

`ifdef WAY_DEC_TRACKER_ERR_EN
    logic r_err;
    logic w_dup_set;
    logic w_spur_clr;

    // A set is a duplicate unless its way is free after this cycle's clear.
    assign w_dup_set  = w_set_acc && ((w_set_oh & ~(r_mask & ~w_clr_oh)) == '0);
    assign w_spur_clr = w_clr_acc && ((w_clr_oh & r_mask) == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= r_err | w_dup_set | w_spur_clr;
        end
    end

    assign err = r_err;
`endif

    assign mask        = r_mask;
    assign count       = r_count;
    assign full        = !rst && (r_count == CNT_W'(WIDTH));
    assign empty       = rst || (r_count == '0);
    assign set_ready   = !rst && (r_state == IDLE) && !full;
    assign clr_ready   = !rst && (r_state == IDLE);
    assign flush_valid = !rst && (r_state == FLUSH) && (r_mask != '0);
    assign flush_idx   = w_low_idx;
    assign flush_done  = !rst && (r_state == DONE);

endmodule

// File: tb/tb_way_dec_tracker.sv
// Directed bench for way_dec_tracker; flush indices are checked against a scoreboard queue.
// Builds with or without WAY_DEC_TRACKER_ERR_EN.
module tb_way_dec_tracker;

    logic       clk = 1'b0;
    logic       rst;
    logic       set_valid;
    logic [2:0] set_idx;
    logic       set_ready;
    logic       clr_valid;
    logic [2:0] clr_idx;
    logic       clr_ready;
    logic       flush_req;
    logic       flush_valid;
    logic [2:0] flush_idx;
    logic       flush_ready;
    logic       flush_done;
    logic [7:0] mask;
    logic [3:0] count;
    logic       full;
    logic       empty;
`ifdef WAY_DEC_TRACKER_ERR_EN
    logic       err;
`endif

    int checks   = 0;
    int failures = 0;
    int exp_q[$];

    way_dec_tracker dut (
        .clk         (clk),
        .rst         (rst),
        .set_valid   (set_valid),
        .set_idx     (set_idx),
        .set_ready   (set_ready),
        .clr_valid   (clr_valid),
        .clr_idx     (clr_idx),
        .clr_ready   (clr_ready),
        .flush_req   (flush_req),
        .flush_valid (flush_valid),
        .flush_idx   (flush_idx),
        .flush_ready (flush_ready),
        .flush_done  (flush_done),
`ifdef WAY_DEC_TRACKER_ERR_EN
        .err         (err),
`endif
        .mask        (mask),
        .count       (count),
        .full        (full),
        .empty       (empty)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_set(input int idx);
        set_valid = 1'b1;
        set_idx   = 3'(idx);
        step();
        set_valid = 1'b0;
    endtask

    task automatic do_clr(input int idx);
        clr_valid = 1'b1;
        clr_idx   = 3'(idx);
        step();
        clr_valid = 1'b0;
    endtask

    // Drain with flush_ready=1 until flush_done, popping the scoreboard on each handshake.
    task automatic drain(input string tag);
        bit seen_done = 1'b0;
        flush_ready = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (flush_done) begin
                seen_done = 1'b1;
                break;
            end
            if (flush_valid) begin
                chk({tag, "_set_ready"}, 32'(set_ready), 32'd0);
                chk({tag, "_clr_ready"}, 32'(clr_ready), 32'd0);
                if (exp_q.size() == 0) begin
                    chk({tag, "_unexpected_idx"}, 32'(flush_idx), 32'hFFFF_FFFF);
                end else begin
                    chk({tag, "_idx"}, 32'(flush_idx), 32'(exp_q.pop_front()));
                end
            end
            step();
        end
        chk({tag, "_done_seen"}, 32'(seen_done), 32'd1);
        chk({tag, "_q_empty"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_mask"}, 32'(mask), 32'd0);
        step();
        chk({tag, "_done_one_cycle"}, 32'(flush_done), 32'd0);
        chk({tag, "_idle"}, 32'(set_ready), 32'd1);
    endtask

    initial begin
        rst = 1'b1; set_valid = 1'b0; set_idx = '0; clr_valid = 1'b0; clr_idx = '0;
        flush_req = 1'b0; flush_ready = 1'b0;
        step();
        step();
        chk("rst_mask", 32'(mask), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_fvalid", 32'(flush_valid), 32'd0);
        chk("rst_fdone", 32'(flush_done), 32'd0);
        chk("rst_set_ready", 32'(set_ready), 32'd0);
        rst = 1'b0;
        step();
        chk("idle_set_ready", 32'(set_ready), 32'd1);

        do_set(3); do_set(5); do_set(0);
        chk("set3_mask", 32'(mask), 32'h29);
        chk("set3_count", 32'(count), 32'd3);
        chk("set3_empty", 32'(empty), 32'd0);

        do_set(1); do_set(2); do_set(4); do_set(6); do_set(7);
        chk("full_flag", 32'(full), 32'd1);
        chk("full_set_ready", 32'(set_ready), 32'd0);
        chk("full_count", 32'(count), 32'd8);
        do_clr(6);
        chk("clr6_mask", 32'(mask), 32'hBF);
        chk("clr6_full", 32'(full), 32'd0);
        set_valid = 1'b1; set_idx = 3'd2; clr_valid = 1'b1; clr_idx = 3'd2;
        step();
        set_valid = 1'b0; clr_valid = 1'b0;
        chk("setclr2_mask", 32'(mask), 32'hBF);
        chk("setclr2_count", 32'(count), 32'd7);
`ifdef WAY_DEC_TRACKER_ERR_EN
        chk("err_clean", 32'(err), 32'd0);
`endif

        do_set(5);
        chk("dup5_mask", 32'(mask), 32'hBF);
        chk("dup5_count", 32'(count), 32'd7);
`ifdef WAY_DEC_TRACKER_ERR_EN
        chk("err_dup", 32'(err), 32'd1);
`endif
        do_clr(6);
        chk("spur6_mask", 32'(mask), 32'hBF);
        chk("spur6_count", 32'(count), 32'd7);

        do_clr(0); do_clr(2); do_clr(3); do_clr(5);
        chk("pre_flush_mask", 32'(mask), 32'h92);
        chk("pre_flush_count", 32'(count), 32'd3);
        exp_q.push_back(1); exp_q.push_back(4); exp_q.push_back(7);
        flush_ready = 1'b1;
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        drain("flush1");

        do_set(1); do_set(4); do_set(7);
        flush_ready = 1'b0;
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        set_valid = 1'b1; set_idx = 3'd0; clr_valid = 1'b1; clr_idx = 3'd7;
        for (int k = 0; k < 3; k++) begin
            chk("stall_valid", 32'(flush_valid), 32'd1);
            chk("stall_idx", 32'(flush_idx), 32'd1);
            chk("stall_mask", 32'(mask), 32'h92);
            chk("stall_set_ready", 32'(set_ready), 32'd0);
            chk("stall_clr_ready", 32'(clr_ready), 32'd0);
            step();
        end
        set_valid = 1'b0; clr_valid = 1'b0;
        exp_q.push_back(1); exp_q.push_back(4); exp_q.push_back(7);
        drain("flush2");

        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        chk("empty_flush_done", 32'(flush_done), 32'd1);
        chk("empty_flush_valid", 32'(flush_valid), 32'd0);
        step();
        chk("empty_flush_done_off", 32'(flush_done), 32'd0);

        do_set(1); do_set(4);
        flush_ready = 1'b0;
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        chk("midrst_valid_before", 32'(flush_valid), 32'd1);
`ifdef WAY_DEC_TRACKER_ERR_EN
        chk("err_sticky", 32'(err), 32'd1);
`endif
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_mask", 32'(mask), 32'd0);
        chk("midrst_fvalid", 32'(flush_valid), 32'd0);
        step();
        chk("midrst_idle_set", 32'(set_ready), 32'd1);
        chk("midrst_idle_clr", 32'(clr_ready), 32'd1);
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_fvalid2", 32'(flush_valid), 32'd0);
`ifdef WAY_DEC_TRACKER_ERR_EN
        chk("err_cleared", 32'(err), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/way_dec_tracker.md
Name: way_dec_tracker

Overview:
- Decode-side companion to the LLC way priority encoder.
- Accepts binary way indices and decodes them one-hot into a registered occupancy mask (set/clear).
- Maintains the occupancy count, full and empty flags.
- On a flush request, drains the mask by re-emitting each occupied index, lowest first, over a valid/ready handshake.
- Sits between the LLC way-allocation logic and the per-set eviction/writeback sequencer.

Parameters:
- WIDTH, 8: number of ways tracked (mask width).
- LOG_WIDTH, 3: index width, equal to clog2(WIDTH).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- set_valid  in  1  request to mark way set_idx occupied.
- set_idx  in  LOG_WIDTH  way index to set.
- set_ready  out  1  set request accepted this cycle.
- clr_valid  in  1  request to mark way clr_idx free.
- clr_idx  in  LOG_WIDTH  way index to clear.
- clr_ready  out  1  clear request accepted this cycle.
- flush_req  in  1  single-cycle pulse; start draining the mask.
- flush_valid  out  1  flush_idx holds an occupied way.
- flush_idx  out  LOG_WIDTH  lowest occupied way index.
- flush_ready  in  1  consumer accepts flush_idx.
- flush_done  out  1  one-cycle pulse when the drain completes.
- mask  out  WIDTH  registered occupancy mask; bit i set means way i is occupied.
- count  out  LOG_WIDTH+1  number of set bits in mask.
- full  out  1  count == WIDTH.
- empty  out  1  count == 0.

Behaviour:
- Reset (rst=1 at posedge): mask=0, count=0, state=IDLE. Outputs: empty=1, full=0, flush_valid=0, flush_done=0, set_ready=0 during the reset cycle. rst overrides every other input, including mid-flush.
- Handshakes: a set is accepted when set_valid&&set_ready; a clear when clr_valid&&clr_ready; a flush step when flush_valid&&flush_ready. mask and count update on the next posedge (1-cycle latency); full and empty are derived from registered count.
- set_ready = (state==IDLE) && !full.
- clr_ready = (state==IDLE).
- Simultaneous accepted set and clr, different indices: both apply; count unchanged.
- Simultaneous accepted set and clr, same index: clear applies first, then set; bit ends 1; count unchanged.
- Set on an already-set bit: mask and count unchanged (duplicate).
- Clr on an already-clear bit: mask and count unchanged (spurious).
- Out-of-range index (>= WIDTH, when WIDTH < 2^LOG_WIDTH): ignored; treated as spurious/duplicate.
- FSM states: IDLE, FLUSH, DONE.
  - IDLE -> FLUSH on flush_req. If mask is empty at that time: IDLE -> DONE directly.
  - FLUSH: flush_valid = |mask; flush_idx = lowest set index of mask. On a flush step, that bit clears and count decrements next cycle. Once mask==0, go to DONE.
  - DONE: flush_done=1 for exactly one cycle, then IDLE.
- flush_req is ignored outside IDLE.
- flush_idx stays stable while flush_valid=1 and flush_ready=0; no other mask writer is active in FLUSH.
- count never wraps: set is blocked at full; a decrement only occurs on a set bit.

Optional Feature:
- Macro: WAY_DEC_TRACKER_ERR_EN.
- When defined: adds output err (1 bit), sticky, cleared only by rst. Asserts the cycle after an accepted duplicate set, spurious clear or out-of-range index.
- When undefined: no err port; these events are silently ignored as described above. Mask, count and handshake behaviour are identical in both builds.

Decomposition:
- Shared LLC package:
  - FSM state enum (IDLE, FLUSH, DONE).
  - Default WIDTH/LOG_WIDTH constants tied to the LLC way count.
- One sub-module: one_hot_dec (index + enable -> WIDTH-bit one-hot). Instantiated twice, once for set and once for clear.
- Lowest-set-bit selection stays inline.

Test Plan:
- Reset, then set idx 3, 5, 0 on consecutive cycles -> mask=8'b0010_1001, count=3, empty=0 one cycle after the last set.
- Set idx 0..7 -> full=1, set_ready=0. Set idx 2 with clr idx 2 in the same cycle (after a prior clr frees room) -> bit 2 ends 1, count unchanged.
- Duplicate set idx 5 and clr of empty idx 6 -> mask and count unchanged. With WAY_DEC_TRACKER_ERR_EN, err=1 next cycle and stays 1 until rst.
- mask=8'b1001_0010, flush_req, flush_ready=1 -> flush_idx 1, 4, 7 on successive cycles; flush_done pulses one cycle after mask==0; state back to IDLE.
- Same flush with flush_ready low for 3 cycles -> flush_idx held at 1, mask unchanged. set_ready=0 and clr_ready=0 throughout FLUSH.
- flush_req with mask=0 -> flush_done the next cycle, no flush_valid. rst asserted mid-flush -> mask=0, IDLE, flush_valid=0 next cycle.
